// File: rtl/life_seq_if.sv
// life_seq_if: host/evaluator-facing signals of the Life generation sequencer.
interface life_seq_if #(parameter int IDX_W = 7, parameter int GEN_W = 16);
    logic             load_valid;
    logic [63:0]      load_board;
    logic             step;
    logic             run;
    logic             next_state;
    logic [IDX_W-1:0] cell_index;
    logic [63:0]      eval_board;
    logic [63:0]      board;
    logic             busy;
    logic             gen_done;
    logic [GEN_W-1:0] gen_count;
    modport master (
        output load_valid, load_board, step, run, next_state,
        input  cell_index, eval_board, board, busy, gen_done, gen_count
    );
    modport slave (
        input  load_valid, load_board, step, run, next_state,
        output cell_index, eval_board, board, busy, gen_done, gen_count
    );
endinterface

// File: rtl/life_generation_sequencer.sv
// life_generation_sequencer: scans an 8x8 toroidal Life board through a registered
// single-cell evaluator and commits the whole next generation at once.
module life_generation_sequencer #(
    parameter int NUM_CELLS = 64,
    parameter int IDX_W     = 7,
    parameter int GEN_W     = 16
) (
    input logic       clk,
    input logic       rst,
    life_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_t;
    localparam logic [IDX_W-2:0] LAST = (IDX_W-1)'(NUM_CELLS - 1);
    state_t               state, state_nx;
    logic [IDX_W-2:0]     idx;
    logic [NUM_CELLS-1:0] board, shadow;
    logic [GEN_W-1:0]     gen;
    logic                 done;
    logic                 start;
    always_comb begin
        start    = state == IDLE && !bus.load_valid && (bus.step || bus.run);
        state_nx = state == IDLE  ? (start ? SCAN : IDLE) :
                   state == SCAN  ? (idx == LAST ? DRAIN : SCAN) :
                   state == DRAIN ? COMMIT :
                   (bus.run ? SCAN : IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // Evaluator output lags cell_index by one cycle, so SCAN writes the previous cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            board  <= '0;
            shadow <= '0;
            gen    <= '0;
            done   <= 1'b0;
        end else begin
            done <= state == COMMIT;
            if (state == IDLE && bus.load_valid) begin
                board <= bus.load_board;
                gen   <= '0;
            end
            if (state != SCAN && state_nx == SCAN) idx <= '0;
            else if (state == SCAN && idx != LAST) idx <= idx + 1'b1;
            if (state == SCAN && idx != '0) shadow[idx - 1'b1] <= bus.next_state;
            if (state == DRAIN) shadow[LAST] <= bus.next_state;
            if (state == COMMIT) begin
                board <= shadow;
                gen   <= gen + 1'b1;
            end
        end
    end
    assign bus.cell_index = {1'b0, idx};
    assign bus.eval_board = board;
    assign bus.board      = board;
    assign bus.busy       = state != IDLE;
    assign bus.gen_done   = done;
    assign bus.gen_count  = gen;
endmodule
